// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative multiply/divide unit for the E stage.
// Runs a shift-add multiplier (MUL/UMULL/SMULL) or a restoring divider
// (UDIV) one bit per cycle. It holds the pipeline stalled while it runs.
// Optional feature macro: MDU_EARLY_OUT_EN. When defined, a multiply leaves
// BUSY as soon as the remaining multiplier bits are all zero.
module mdu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic [1:0]       OpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             Abort,
  output logic             MdustallE,
  output logic             ResultValid,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic             WrHiValid,
  output logic             DivZero,
  output logic             Busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULL = 2'b01,
    OP_SMULL = 2'b10,
    OP_UDIV  = 2'b11
  } op_t;

  state_t           state, state_d;
  op_t              op, op_d;
  logic             sign, sign_d;
  logic             dz, dz_d;
  logic [CW-1:0]    cnt, cnt_d;
  // The multiplicand register doubles as the divisor register.
  logic [WIDTH-1:0] mcand, mcand_d;
  logic [WIDTH-1:0] mplr, mplr_d;
  // Divide keeps the remainder in the upper half and the dividend/quotient
  // in the lower half, so the final split matches the product layout.
  logic [2*WIDTH-1:0] acc, acc_d;
  logic [WIDTH-1:0] res_lo, res_hi;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     add_hi;
  logic [2*WIDTH:0]   mul_wide;
  logic [2*WIDTH:0]   mul_shift1;
  logic [2*WIDTH:0]   mul_early;
  logic               early;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic               borrow;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] div_next;

  // Single-step datapath for multiply and divide.
  always_comb begin
    mag_a      = SrcAE[WIDTH-1] ? -SrcAE : SrcAE;
    mag_b      = SrcBE[WIDTH-1] ? -SrcBE : SrcBE;
    addend     = mplr[0] ? mcand : '0;
    add_hi     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    mul_wide   = {add_hi, acc[WIDTH-1:0]};
    mul_shift1 = mul_wide >> 1;
    mul_early  = mul_wide >> cnt;
`ifdef MDU_EARLY_OUT_EN
    early      = (op != OP_UDIV) && (mplr[WIDTH-1:1] == '0);
`else
    early      = 1'b0;
`endif
    shifted    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff       = {1'b0, shifted} - {2'b00, mcand};
    borrow     = diff[WIDTH+1];
    rem_next   = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    div_next   = {rem_next, acc[WIDTH-2:0], ~borrow};
  end

  // Next-state and next-datapath logic; Abort overrides everything.
  always_comb begin
    state_d = state;
    op_d    = op;
    sign_d  = sign;
    dz_d    = dz;
    cnt_d   = cnt;
    mcand_d = mcand;
    mplr_d  = mplr;
    acc_d   = acc;
    case (state)
      IDLE: begin
        if (StartE && !Abort) begin
          op_d    = op_t'(OpE);
          cnt_d   = CW'(WIDTH);
          acc_d   = '0;
          sign_d  = 1'b0;
          dz_d    = 1'b0;
          mcand_d = SrcAE;
          mplr_d  = SrcBE;
          state_d = BUSY;
          case (op_t'(OpE))
            OP_SMULL: begin
              sign_d  = SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1];
              mcand_d = mag_a;
              mplr_d  = mag_b;
            end
            OP_UDIV: begin
              mcand_d = SrcBE;
              mplr_d  = '0;
              acc_d   = {{WIDTH{1'b0}}, SrcAE};
              if (SrcBE == '0) begin
                dz_d    = 1'b1;
                acc_d   = {SrcAE, {WIDTH{1'b0}}};
                state_d = DONE;
              end
            end
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt - CW'(1);
        if (op == OP_UDIV) begin
          acc_d = div_next;
        end else if (early) begin
          acc_d  = mul_early[2*WIDTH-1:0];
          mplr_d = '0;
        end else begin
          acc_d  = mul_shift1[2*WIDTH-1:0];
          mplr_d = mplr >> 1;
        end
        if (cnt == CW'(1) || early)
          state_d = (op == OP_SMULL && sign) ? FIX : DONE;
      end
      FIX: begin
        acc_d   = -acc;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (Abort) state_d = IDLE;
  end

  // State, datapath and result registers; results load on entry to DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      op     <= OP_MUL;
      sign   <= 1'b0;
      dz     <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      acc    <= '0;
      res_lo <= '0;
      res_hi <= '0;
    end else begin
      state <= state_d;
      op    <= op_d;
      sign  <= sign_d;
      dz    <= dz_d;
      cnt   <= cnt_d;
      mcand <= mcand_d;
      mplr  <= mplr_d;
      acc   <= acc_d;
      if (state_d == DONE && state != DONE) begin
        res_lo <= acc_d[WIDTH-1:0];
        res_hi <= acc_d[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Output decode; reset is folded into the stall so it drops immediately.
  always_comb begin
    MdustallE   = reset && !Abort &&
                  (((state == IDLE) && StartE) || state == BUSY || state == FIX);
    ResultValid = (state == DONE) && !Abort;
    WrHiValid   = ResultValid && (op == OP_UMULL || op == OP_SMULL);
    DivZero     = ResultValid && dz;
    Busy        = (state != IDLE);
    ResultLo    = res_lo;
    ResultHi    = res_hi;
  end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Iterative multiply/divide sequencer for the execute stage of the pipelined ARM core. It accepts a MUL, UMULL, SMULL or UDIV held in the E stage and runs a shift-add multiplier or restoring divider, one bit per cycle. While it runs, it requests a pipeline stall from the hazard logic. On completion it presents a low result for write port 1 and a high result for write port 2 (RegWrite2), as the instruction advances to M.

## Interface
Parameters:
- WIDTH, 32, operand width; products are 2*WIDTH.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- StartE  in  1  valid MDU instruction in E with its condition passed.
- OpE  in  2  operation: 00 MUL (low word only), 01 UMULL, 10 SMULL, 11 UDIV.
- SrcAE  in  WIDTH  multiplicand or dividend.
- SrcBE  in  WIDTH  multiplier or divisor.
- Abort  in  1  synchronous cancel of the current operation (exception or redirect).
- MdustallE  out  1  stall request; the hazard unit ORs it into StallF/StallD/StallE and bubbles M.
- ResultValid  out  1  high only in the DONE cycle.
- ResultLo  out  WIDTH  product[WIDTH-1:0] or quotient.
- ResultHi  out  WIDTH  product[2*WIDTH-1:WIDTH] or remainder.
- WrHiValid  out  1  high in DONE for UMULL/SMULL; drives RegWrite2 for the instruction.
- DivZero  out  1  one-cycle pulse in DONE when a UDIV divisor is 0.
- Busy  out  1  state is not IDLE.

## Operation
States: IDLE, BUSY, FIX, DONE.

- **IDLE**
  - On StartE & ~Abort:
    - latch OpE and the operands;
    - for SMULL, latch magnitudes and record sign = SrcAE[MSB]^SrcBE[MSB];
    - load counter = WIDTH and clear the 2*WIDTH accumulator;
    - go to BUSY.
  - UDIV with SrcBE==0 goes directly to DONE with quotient 0, remainder = SrcAE, and DivZero asserted.
- **BUSY**
  - Multiply: if multiplier LSB is 1, add the multiplicand to the upper accumulator half; then shift the accumulator/multiplier right by 1.
  - Divide (restoring): shift the remainder left with the next dividend bit, subtract the divisor, keep the result if it is non-negative; quotient bit = ~borrow.
  - Counter decrements each cycle. When it reaches 1, go to FIX if the operation is SMULL and sign=1, else to DONE.
- **FIX**: two's-complement negate the 2*WIDTH accumulator; go to DONE.
- **DONE**: ResultValid=1 with results stable; go to IDLE unconditionally.
- StartE is ignored outside IDLE. The same instruction is still in E during BUSY/FIX and must not restart.
- MdustallE = (IDLE & StartE & ~Abort) | BUSY | FIX. It is 0 in DONE, so the instruction leaves E in that cycle carrying the results.
- Abort in any state: next state is IDLE, MdustallE is forced 0 that cycle, and no ResultValid is produced.
- All arithmetic is unsigned on WIDTH+1 bits internally (carry/borrow). Results wrap modulo 2^(2*WIDTH).
- Reset at any time: state IDLE. ResultLo/ResultHi/accumulator = 0; all 1-bit outputs = 0.

## Timing
- Cycle 0: StartE in IDLE, with MdustallE=1 combinationally.
- Cycles 1..WIDTH: BUSY.
- Cycle WIDTH+1: FIX, SMULL with a negative result only.
- Next cycle: DONE.
- Stall length:
  - MUL/UMULL/UDIV and positive SMULL: WIDTH+1 cycles;
  - negative SMULL: WIDTH+2 cycles;
  - UDIV by zero: 1 cycle.
- Results are registered; ResultLo/Hi hold their value until the next operation completes.
- A StartE in the cycle after DONE (the next instruction) is accepted normally; there is no dead cycle.

## Configuration
- MDU_EARLY_OUT_EN defined: in BUSY for MUL/UMULL/SMULL, when the remaining unshifted multiplier bits are all zero, the accumulator is aligned by a barrel shift of the remaining count and the sequencer exits BUSY that cycle (to FIX or DONE). Minimum BUSY length is 1 cycle. UDIV is unaffected.
- Undefined: fixed latency as in Timing.

## Test plan
- UMULL 0xFFFFFFFF × 0xFFFFFFFF -> DONE at cycle 33; ResultHi=0xFFFFFFFE, ResultLo=0x00000001, WrHiValid=1; MdustallE high cycles 0–32.
- SMULL -3 × 5 -> passes through FIX; DONE at cycle 34; Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
- UDIV 100 / 7 -> Lo=14, Hi=2, DivZero=0.
- UDIV 123 / 0 -> DONE at cycle 1; Lo=0, Hi=123, DivZero pulses once.
- MUL 6 × 7 -> Lo=42, WrHiValid=0. DONE at cycle 33 without the macro; with MDU_EARLY_OUT_EN, DONE by cycle 4.
- UMULL started, Abort at cycle 10 -> IDLE at cycle 11, no ResultValid, MdustallE 0 in cycle 10. Separately, reset pulled low at cycle 5 -> all outputs 0 immediately.
